// File: rtl/apb_to_axi4lite_bridge_pkg.sv
// apb_axi_pkg: shared types and constants for the APB to AXI4-Lite bridge
// Contents: bridge FSM state enum, AXI response codes, protection width,
// and a helper that maps an AXI response to an APB error flag.
package apb_axi_pkg;
  localparam int PROT_W = 3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  function automatic logic resp_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction
endpackage

// File: rtl/apb_to_axi4lite_bridge_if.sv
// apb_if / axil_if: bus bundles for the APB completer side and AXI4-Lite manager side
// apb_if   : psel, penable, pwrite, paddr, pwdata, pstrb, pprot (requester -> completer)
//            pready, prdata, pslverr (completer -> requester)
// axil_if  : AW/W/B/AR/R channels of AXI4-Lite; master drives valids/payloads and b/r ready
interface apb_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  import apb_axi_pkg::*;
  localparam int STRB_W = DATA_W / 8;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [PROT_W-1:0] pprot;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                  input pready, prdata, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                  output pready, prdata, pslverr);
endinterface

interface axil_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  import apb_axi_pkg::*;
  localparam int STRB_W = DATA_W / 8;
  logic [ADDR_W-1:0] awaddr;
  logic [PROT_W-1:0] awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [PROT_W-1:0] arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  modport master (output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                         araddr, arprot, arvalid, rready,
                  input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
  modport slave  (input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                        araddr, arprot, arvalid, rready,
                  output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/apb_to_axi4lite_bridge.sv
// apb_to_axi4lite_bridge: APB completer turning each transfer into one AXI4-Lite transaction
// i_aclk    : clock shared by both buses
// i_aresetn : asynchronous active-low reset
// apb       : APB completer port (wait states via pready until the AXI response returns)
// axi       : AXI4-Lite manager port, single outstanding transaction
module apb_to_axi4lite_bridge
  import apb_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic    i_aclk,
  input  logic    i_aresetn,
  apb_if.slave    apb,
  axil_if.master  axi
);
  localparam int STRB_W = DATA_W / 8;
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("DATA_W must be 32 or 64");
  end
  state_t            r_state, w_next;
  logic              r_aw_done, r_w_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [PROT_W-1:0] r_prot;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [STRB_W-1:0] r_strb;
  logic              w_aw_hs, w_w_hs, w_b_hs, w_r_hs;
  assign axi.awaddr  = r_addr;
  assign axi.awprot  = r_prot;
  assign axi.awvalid = (r_state == WR_REQ) && !r_aw_done;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_strb;
  assign axi.wvalid  = (r_state == WR_REQ) && !r_w_done;
  assign axi.bready  = (r_state == WR_RESP);
  assign axi.araddr  = r_addr;
  assign axi.arprot  = r_prot;
  assign axi.arvalid = (r_state == RD_REQ);
  assign axi.rready  = (r_state == RD_RESP);
  assign w_aw_hs = axi.awvalid && axi.awready;
  assign w_w_hs  = axi.wvalid && axi.wready;
  assign w_b_hs  = axi.bvalid && axi.bready;
  assign w_r_hs  = axi.rvalid && axi.rready;
  // the result is only presented during the APB access phase; outside it both stay 0
  assign apb.pready  = (r_state == DONE) && apb.psel && apb.penable;
  assign apb.prdata  = apb.pready ? r_rdata : '0;
  assign apb.pslverr = apb.pready && r_err;
  always_ff @(posedge i_aclk or negedge i_aresetn)
    if (!i_aresetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !apb.psel ? IDLE : apb.pwrite ? WR_REQ : RD_REQ;
      WR_REQ:  w_next = ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) ? WR_RESP : WR_REQ;
      WR_RESP: w_next = axi.bvalid ? DONE : WR_RESP;
      RD_REQ:  w_next = axi.arready ? RD_RESP : RD_REQ;
      RD_RESP: w_next = axi.rvalid ? DONE : RD_RESP;
      // a dropped psel abandons the result; a completed access phase ends the transfer
      DONE:    w_next = (!apb.psel || apb.penable) ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_aclk or negedge i_aresetn)
    if (!i_aresetn) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_prot    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_strb    <= '0;
    end else begin
      if (r_state == IDLE && apb.psel) begin
        r_addr    <= apb.paddr;
        r_prot    <= apb.pprot;
        r_wdata   <= apb.pwdata;
        r_strb    <= apb.pwrite ? apb.pstrb : '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) r_w_done <= 1'b1;
      if (w_b_hs) begin
        r_err   <= resp_err(axi.bresp);
        r_rdata <= '0;
      end
      if (w_r_hs) begin
        r_err   <= resp_err(axi.rresp);
        r_rdata <= axi.rdata;
      end
    end
endmodule

// File: tb/tb_apb_to_axi4lite_bridge.sv
// tb_apb_to_axi4lite_bridge: vector table plus scoreboarded AXI slave for the bridge
module tb_apb_to_axi4lite_bridge;
  import apb_axi_pkg::*;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_prd;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  apb_if  #(.ADDR_W(32), .DATA_W(32)) apb ();
  axil_if #(.ADDR_W(32), .DATA_W(32)) axi ();
  apb_to_axi4lite_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_aclk(clk), .i_aresetn(rstn), .apb(apb), .axi(axi)
  );
  int n_chk = 0, n_err = 0;
  int aw_d, w_d, b_d, ar_d, r_d;
  logic [1:0] resp_cfg;
  logic [31:0] rdata_cfg;
  int n_aw, n_w, n_ar, n_b, n_r;
  int aw_c, w_c, ar_c, b_c, r_c;
  logic [34:0] q_aw[$], q_ar[$];
  logic [35:0] q_w[$];
  logic [32:0] q_apb[$];
  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot,
                              input int aw, input int w, input int b, input int ar, input int r,
                              input logic [1:0] resp, input logic [31:0] rdata,
                              input logic exp_err, input logic [31:0] exp_prd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.aw_d = aw; v.w_d = w; v.b_d = b; v.ar_d = ar; v.r_d = r;
    v.resp = resp; v.rdata = rdata; v.exp_err = exp_err; v.exp_prd = exp_prd;
    return v;
  endfunction

  // AXI4-Lite slave: readies/responses change on the falling edge after a per-channel delay
  initial begin
    logic [34:0] e35;
    logic [35:0] e36;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    forever begin
      @(negedge clk);
      if (axi.awvalid) begin axi.awready = (aw_c >= aw_d); aw_c++; end
      else begin axi.awready = 0; aw_c = 0; end
      if (axi.wvalid) begin axi.wready = (w_c >= w_d); w_c++; end
      else begin axi.wready = 0; w_c = 0; end
      if (axi.arvalid) begin axi.arready = (ar_c >= ar_d); ar_c++; end
      else begin axi.arready = 0; ar_c = 0; end
      if (axi.bready) begin axi.bvalid = (b_c >= b_d); b_c++; end
      else begin axi.bvalid = 0; b_c = 0; end
      if (axi.rready) begin axi.rvalid = (r_c >= r_d); r_c++; end
      else begin axi.rvalid = 0; r_c = 0; end
      axi.bresp = resp_cfg;
      axi.rresp = resp_cfg;
      axi.rdata = rdata_cfg;
      if (axi.awvalid && axi.awready) begin
        n_aw++;
        if (q_aw.size() == 0) check("aw_unexpected", {axi.awprot, axi.awaddr}, 0);
        else begin e35 = q_aw.pop_front(); check("aw_payload", {axi.awprot, axi.awaddr}, e35); end
      end
      if (axi.wvalid && axi.wready) begin
        n_w++;
        if (q_w.size() == 0) check("w_unexpected", {axi.wstrb, axi.wdata}, 0);
        else begin e36 = q_w.pop_front(); check("w_payload", {axi.wstrb, axi.wdata}, e36); end
      end
      if (axi.arvalid && axi.arready) begin
        n_ar++;
        if (q_ar.size() == 0) check("ar_unexpected", {axi.arprot, axi.araddr}, 0);
        else begin e35 = q_ar.pop_front(); check("ar_payload", {axi.arprot, axi.araddr}, e35); end
      end
      if (axi.bvalid && axi.bready) n_b++;
      if (axi.rvalid && axi.rready) n_r++;
    end
  end

  // one APB transfer, entered and left just after a rising edge
  task automatic apb_xfer(input vec_t v, output logic [31:0] prd, output logic err, output int waits);
    bit ok, bad;
    apb.psel = 1; apb.penable = 0; apb.pwrite = v.wr; apb.paddr = v.addr;
    apb.pwdata = v.wdata; apb.pstrb = v.strb; apb.pprot = v.prot;
    @(negedge clk);
    check("setup_idle", {apb.pready, apb.pslverr, apb.prdata}, 0);
    @(posedge clk); #1 apb.penable = 1;
    waits = 0; ok = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (apb.pready) begin ok = 1; break; end
      waits++;
      if (apb.prdata !== 0 || apb.pslverr !== 0) bad = 1;
    end
    check("pready_seen", ok, 1);
    check("wait_outputs_zero", bad, 0);
    check("axi_quiet_at_pready", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    prd = apb.prdata; err = apb.pslverr;
    @(posedge clk); #1 apb.psel = 0; apb.penable = 0;
  endtask

  task automatic run(input vec_t v);
    logic [31:0] prd;
    logic err;
    int waits, exp_w;
    logic [32:0] e;
    aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d; ar_d = v.ar_d; r_d = v.r_d;
    resp_cfg = v.resp; rdata_cfg = v.rdata;
    n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0;
    if (v.wr) begin
      q_aw.push_back({v.prot, v.addr});
      q_w.push_back({v.strb, v.wdata});
    end else q_ar.push_back({v.prot, v.addr});
    q_apb.push_back({v.exp_err, v.exp_prd});
    exp_w = v.wr ? 2 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d : 2 + v.ar_d + v.r_d;
    apb_xfer(v, prd, err, waits);
    e = q_apb.pop_front();
    check("prdata", prd, e[31:0]);
    check("pslverr", err, e[32]);
    check("wait_states", waits, exp_w);
    check("n_aw", n_aw, v.wr ? 1 : 0);
    check("n_w", n_w, v.wr ? 1 : 0);
    check("n_b", n_b, v.wr ? 1 : 0);
    check("n_ar", n_ar, v.wr ? 0 : 1);
    check("n_r", n_r, v.wr ? 0 : 1);
    if (!v.wr) check("wstrb_on_read", axi.wstrb, 0);
  endtask

  initial begin
    vec_t v;
    bit ok;
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 0;
    apb.pwdata = 0; apb.pstrb = 0; apb.pprot = 0;
    aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; resp_cfg = 0; rdata_cfg = 0;
    vt[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 0, 0, 0, RESP_OKAY,   32'h0,        0, 32'h0);
    vt[1] = mk(1, 32'h20, 32'hA5A50000, 4'h3, 3'd1, 3, 0, 0, 0, 0, RESP_OKAY,   32'h0,        0, 32'h0);
    vt[2] = mk(0, 32'h30, 32'h0,        4'hF, 3'd2, 0, 0, 0, 2, 3, RESP_OKAY,   32'h12345678, 0, 32'h12345678);
    vt[3] = mk(0, 32'h40, 32'h0,        4'hF, 3'd0, 0, 0, 0, 0, 0, RESP_DECERR, 32'h0,        1, 32'h0);
    vt[4] = mk(1, 32'h44, 32'h11112222, 4'hC, 3'd0, 1, 2, 2, 0, 0, RESP_EXOKAY, 32'h0,        0, 32'h0);
    vt[5] = mk(1, 32'h48, 32'h33334444, 4'hF, 3'd4, 0, 0, 1, 0, 0, RESP_SLVERR, 32'h0,        1, 32'h0);
    vt[6] = mk(0, 32'h4C, 32'h0,        4'h0, 3'd7, 0, 0, 0, 1, 0, RESP_EXOKAY, 32'hFFFF0001, 0, 32'hFFFF0001);
    vt[7] = mk(1, 32'h60, 32'h55AA55AA, 4'h9, 3'd3, 0, 2, 0, 0, 0, RESP_OKAY,   32'hFFFF0001, 0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_outputs", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                            apb.pready, apb.pslverr, apb.prdata}, 0);
    check("reset_regs", {axi.awaddr, axi.wstrb, axi.awprot}, 0);
    @(posedge clk); #1 rstn = 1;
    for (int i = 0; i < 8; i++) begin
      run(vt[i]);
      repeat (2) @(posedge clk);
      #1;
    end
    // reset while waiting for the write response
    v = mk(1, 32'h50, 32'hCAFE0000, 4'hF, 3'd0, 0, 0, 1000, 0, 0, RESP_OKAY, 32'h0, 0, 32'h0);
    aw_d = 0; w_d = 0; b_d = 1000;
    q_aw.push_back({v.prot, v.addr});
    q_w.push_back({v.strb, v.wdata});
    apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = v.addr;
    apb.pwdata = v.wdata; apb.pstrb = v.strb; apb.pprot = v.prot;
    @(posedge clk); #1 apb.penable = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.bready) begin ok = 1; break; end
    end
    check("bready_before_reset", ok, 1);
    #2 rstn = 0;
    #1 check("async_reset_drop", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                                  apb.pready, apb.pslverr}, 0);
    apb.psel = 0; apb.penable = 0;
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;
    run(mk(0, 32'h70, 32'h0, 4'hF, 3'd0, 0, 0, 0, 1, 1, RESP_OKAY, 32'h89ABCDEF, 0, 32'h89ABCDEF));
    @(posedge clk); #1;
    // back-to-back: second setup right after the first pready
    run(mk(1, 32'h0, 32'h01020304, 4'hF, 3'd0, 0, 0, 0, 0, 0, RESP_OKAY, 32'h0, 0, 32'h0));
    run(mk(0, 32'h4, 32'h0, 4'hF, 3'd0, 0, 0, 0, 0, 0, RESP_OKAY, 32'h0BADF00D, 0, 32'h0BADF00D));
    repeat (3) @(posedge clk);
    check("queues_drained", q_aw.size() + q_w.size() + q_ar.size() + q_apb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
